emu_run_ctrl: RTL and testbench

Host-side run controller for the emulation system. It sequences the target between running, paused and scan (checkpoint) phases. It gates `run_mode` on target tick boundaries and counts committed target cycles. It runs a single-step down-counter and records why the target stopped. It sits between the host control registers and the EMU_SYSTEM `run_mode` / `scan_mode` / `idle` / `tick` pins.

---
 rtl/emu_run_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_emu_run_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_run_ctrl.sv
// -----------------------------------------------------------------------------
// emu_run_ctrl
//
// Host-side run controller for the emulation system. It sequences the target
// between RUN, PAUSED and the two checkpoint-scan phases (SCAN_WAIT, SCAN).
// The target is only stopped on a tick, so it always halts on a committed
// target-cycle boundary. The block also counts committed target cycles, runs a
// single-step down-counter and records why the target stopped.
//
// Ports
//   host_clk     in   host clock, all logic on the rising edge
//   host_rst_n   in   asynchronous active-low reset
//   tick         in   a target cycle commits in this host cycle
//   trig         in   target trap/breakpoint trigger (level)
//   idle         in   emulation models quiescent, required before scan
//   pause_req    in   host pause request (pulse)
//   resume_req   in   host resume request (pulse)
//   scan_req     in   host checkpoint-scan request (pulse)
//   scan_done    in   scan engine finished (pulse)
//   count_wr     in   load the cycle counter with count_wdata
//   count_wdata  in   cycle counter load value
//   step_wr      in   load the step counter with step_wdata
//   step_wdata   in   step counter load value, 0 disables stepping
//   run_mode     out  target allowed to advance (state RUN)
//   scan_mode    out  scan chains selected (state SCAN)
//   count        out  committed target cycles
//   step         out  remaining steps
//   cause        out  stop cause {pause, step, trig}, sticky until resume
//   stop_evt     out  one-cycle pulse on RUN -> PAUSED
//   busy         out  high in SCAN_WAIT or SCAN
// -----------------------------------------------------------------------------
module emu_run_ctrl #(
    parameter int unsigned CNT_W     = 64,
    parameter bit          RESET_RUN = 1'b1
) (
    input  logic             host_clk,
    input  logic             host_rst_n,
    input  logic             tick,
    input  logic             trig,
    input  logic             idle,
    input  logic             pause_req,
    input  logic             resume_req,
    input  logic             scan_req,
    input  logic             scan_done,
    input  logic             count_wr,
    input  logic [CNT_W-1:0] count_wdata,
    input  logic             step_wr,
    input  logic [CNT_W-1:0] step_wdata,
    output logic             run_mode,
    output logic             scan_mode,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] step,
    output logic [2:0]       cause,
    output logic             stop_evt,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_PAUSED    = 2'd1,
        ST_SCAN_WAIT = 2'd2,
        ST_SCAN      = 2'd3
    } state_t;

    localparam state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_PAUSED;

    state_t           r_state;
    logic             r_run_mode;
    logic             r_scan_mode;
    logic             r_busy;
    logic             r_stop_evt;
    logic [2:0]       r_cause;
    logic             r_pause_pend;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_step;

    logic [CNT_W-1:0] w_step_next;
    logic             w_step_trig;
    logic             w_adv;
    logic             w_pause_any;
    logic             w_stop;

    // A target cycle is committed (and counted) only while running.
    assign w_adv = r_run_mode & tick;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_step_next = r_step;
        if (step_wr) begin
            w_step_next = step_wdata;
        end else if (r_step == '0) begin
            w_step_next = '0;
        end else if (w_adv) begin
            w_step_next = r_step - 1'b1;
        end
    end

    // Fires only on the transition to zero; a load in the same cycle
    // overrides the decrement, so a nonzero load suppresses the trigger.
    assign w_step_trig = (r_step != '0) && (w_step_next == '0);

    assign w_pause_any = r_pause_pend | pause_req;
    assign w_stop      = tick & (trig | w_step_trig | w_pause_any);

    // Control FSM with registered outputs. Each transition updates the
    // output registers together with the state so they never lag it.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge host_clk or negedge host_rst_n) begin
        if (!host_rst_n) begin
            r_state      <= RESET_STATE;
            r_run_mode   <= RESET_RUN;
            r_scan_mode  <= 1'b0;
            r_busy       <= 1'b0;
            r_stop_evt   <= 1'b0;
            r_cause      <= 3'b000;
            r_pause_pend <= 1'b0;
        end else begin
            r_stop_evt <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_stop) begin
                        r_state      <= ST_PAUSED;
                        r_run_mode   <= 1'b0;
                        r_stop_evt   <= 1'b1;
                        r_cause      <= {w_pause_any, w_step_trig, trig};
                        r_pause_pend <= 1'b0;
                    end else if (pause_req) begin
                        // Hold the request until the next tick boundary.
                        r_pause_pend <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    // scan_req wins; a same-cycle resume_req is dropped.
                    if (scan_req) begin
                        r_state <= ST_SCAN_WAIT;
                        r_busy  <= 1'b1;
                    end else if (resume_req) begin
                        r_state    <= ST_RUN;
                        r_run_mode <= 1'b1;
                        r_cause    <= 3'b000;
                    end
                end
                ST_SCAN_WAIT: begin
                    if (idle) begin
                        r_state     <= ST_SCAN;
                        r_scan_mode <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // cause is left untouched so it survives the checkpoint.
                    if (scan_done) begin
                        r_state     <= ST_PAUSED;
                        r_scan_mode <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= RESET_STATE;
                    r_run_mode   <= RESET_RUN;
                    r_scan_mode  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_pause_pend <= 1'b0;
                end
            endcase
        end
    end

    // Cycle counter: a host load beats the increment; wraps modulo 2^CNT_W.
    always_ff @(posedge host_clk or negedge host_rst_n) begin
        if (!host_rst_n) begin
            r_count <= '0;
        end else if (count_wr) begin
            r_count <= count_wdata;
        end else if (w_adv) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge host_clk or negedge host_rst_n) begin
        if (!host_rst_n) begin
            r_step <= '0;
        end else begin
            r_step <= w_step_next;
        end
    end

    assign run_mode  = r_run_mode;
    assign scan_mode = r_scan_mode;
    assign busy      = r_busy;
    assign stop_evt  = r_stop_evt;
    assign cause     = r_cause;
    assign count     = r_count;
    assign step      = r_step;

endmodule

// File: tb/tb_emu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_emu_run_ctrl
//
// Bench for emu_run_ctrl. A stimulus process applies one input vector per
// host cycle, advances a behavioural model of the controller by the vector
// the DUT just sampled and queues the expected outputs. A monitor pops the
// queue on every falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_emu_run_ctrl;

    localparam int CNT_W = 64;

    typedef struct packed {
        logic             tick;
        logic             trig;
        logic             idle;
        logic             pause_req;
        logic             resume_req;
        logic             scan_req;
        logic             scan_done;
        logic             count_wr;
        logic [CNT_W-1:0] count_wdata;
        logic             step_wr;
        logic [CNT_W-1:0] step_wdata;
    } stim_t;

    typedef struct packed {
        logic             run_mode;
        logic             scan_mode;
        logic             busy;
        logic             stop_evt;
        logic [2:0]       cause;
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] step;
    } exp_t;

    typedef enum int {PH_RUN, PH_PAUSED, PH_SCAN_WAIT, PH_SCAN} phase_t;

    logic             host_clk = 1'b0;
    logic             host_rst_n;
    logic             tick, trig, idle, pause_req, resume_req, scan_req, scan_done;
    logic             count_wr, step_wr;
    logic [CNT_W-1:0] count_wdata, step_wdata;
    logic             run_mode, scan_mode, stop_evt, busy;
    logic [CNT_W-1:0] count, step;
    logic [2:0]       cause;

    int n_checks = 0;
    int n_errors = 0;

    exp_t  exp_q[$];
    stim_t prev;

    // Behavioural model state.
    phase_t           m_ph;
    logic [CNT_W-1:0] m_count, m_step;
    logic [2:0]       m_cause;
    bit               m_pause_pend, m_stop_evt;

    emu_run_ctrl #(.CNT_W(CNT_W), .RESET_RUN(1'b1)) dut (
        .host_clk   (host_clk),
        .host_rst_n (host_rst_n),
        .tick       (tick),
        .trig       (trig),
        .idle       (idle),
        .pause_req  (pause_req),
        .resume_req (resume_req),
        .scan_req   (scan_req),
        .scan_done  (scan_done),
        .count_wr   (count_wr),
        .count_wdata(count_wdata),
        .step_wr    (step_wr),
        .step_wdata (step_wdata),
        .run_mode   (run_mode),
        .scan_mode  (scan_mode),
        .count      (count),
        .step       (step),
        .cause      (cause),
        .stop_evt   (stop_evt),
        .busy       (busy)
    );

    always #5 host_clk = ~host_clk;

    task automatic check(input string name, input logic [CNT_W-1:0] act,
                         input logic [CNT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic model_reset();
        m_ph         = PH_RUN;
        m_count      = '0;
        m_step       = '0;
        m_cause      = 3'b000;
        m_pause_pend = 1'b0;
        m_stop_evt   = 1'b0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.run_mode  = (m_ph == PH_RUN);
        e.scan_mode = (m_ph == PH_SCAN);
        e.busy      = (m_ph == PH_SCAN_WAIT) || (m_ph == PH_SCAN);
        e.stop_evt  = m_stop_evt;
        e.cause     = m_cause;
        e.count     = m_count;
        e.step      = m_step;
        return e;
    endfunction

    // Advance the model by one host cycle with the inputs the DUT sampled.
    task automatic model_apply(input stim_t s);
        bit               running, committed, step_expired, pause_seen;
        logic [CNT_W-1:0] new_step;
        running   = (m_ph == PH_RUN);
        committed = running && s.tick;

        if (s.step_wr)             new_step = s.step_wdata;
        else if (m_step == 0)      new_step = 0;
        else if (committed)        new_step = m_step - 1;
        else                       new_step = m_step;
        step_expired = (m_step != 0) && (new_step == 0);

        if (s.count_wr)            m_count = s.count_wdata;
        else if (committed)        m_count = m_count + 1;
        m_step = new_step;

        m_stop_evt = 1'b0;
        pause_seen = m_pause_pend || s.pause_req;
        case (m_ph)
            PH_RUN: begin
                if (s.tick && (s.trig || step_expired || pause_seen)) begin
                    m_cause      = {pause_seen, step_expired, s.trig};
                    m_stop_evt   = 1'b1;
                    m_pause_pend = 1'b0;
                    m_ph         = PH_PAUSED;
                end else if (s.pause_req) begin
                    m_pause_pend = 1'b1;
                end
            end
            PH_PAUSED: begin
                if (s.scan_req) m_ph = PH_SCAN_WAIT;
                else if (s.resume_req) begin
                    m_ph    = PH_RUN;
                    m_cause = 3'b000;
                end
            end
            PH_SCAN_WAIT: if (s.idle) m_ph = PH_SCAN;
            PH_SCAN:      if (s.scan_done) m_ph = PH_PAUSED;
            default:      m_ph = PH_RUN;
        endcase
    endtask

    task automatic drive(input stim_t s);
        tick        = s.tick;
        trig        = s.trig;
        idle        = s.idle;
        pause_req   = s.pause_req;
        resume_req  = s.resume_req;
        scan_req    = s.scan_req;
        scan_done   = s.scan_done;
        count_wr    = s.count_wr;
        count_wdata = s.count_wdata;
        step_wr     = s.step_wr;
        step_wdata  = s.step_wdata;
    endtask

    // One host cycle: account for the edge just taken, then present s.
    task automatic cyc(input stim_t s);
        @(posedge host_clk);
        #1;
        model_apply(prev);
        exp_q.push_back(model_out());
        drive(s);
        prev = s;
    endtask

    task automatic reset_dut();
        @(posedge host_clk);
        #1;
        host_rst_n = 1'b0;
        #1;
        check("async_reset_scan_mode", {63'd0, scan_mode}, 64'd0);
        model_reset();
        exp_q.push_back(model_out());
        drive(nop());
        prev = nop();
        @(posedge host_clk);
        #1;
        exp_q.push_back(model_out());
        host_rst_n = 1'b1;
    endtask

    // Scoreboard monitor: compare on the falling edge, away from sampling.
    always @(negedge host_clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("run_mode",  {63'd0, run_mode},  {63'd0, e.run_mode});
            check("scan_mode", {63'd0, scan_mode}, {63'd0, e.scan_mode});
            check("busy",      {63'd0, busy},      {63'd0, e.busy});
            check("stop_evt",  {63'd0, stop_evt},  {63'd0, e.stop_evt});
            check("cause",     {61'd0, cause},     {61'd0, e.cause});
            check("count",     count,              e.count);
            check("step",      step,               e.step);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        host_rst_n = 1'b0;
        drive(nop());
        prev = nop();
        model_reset();
        repeat (3) @(posedge host_clk);
        #1;
        exp_q.push_back(model_out());
        host_rst_n = 1'b1;

        // Ten ticks straight out of reset.
        s = nop(); s.tick = 1'b1;
        repeat (10) cyc(s);
        cyc(nop());
        check("ten_ticks_count", count, 64'd10);
        check("ten_ticks_run", {63'd0, run_mode}, 64'd1);

        // Pause request held until the tick three cycles later.
        s = nop(); s.pause_req = 1'b1;
        cyc(s);
        cyc(nop()); cyc(nop());
        s = nop(); s.tick = 1'b1;
        cyc(s);
        cyc(nop()); cyc(nop());
        check("pause_cause", {61'd0, cause}, 64'd4);
        check("pause_count", count, 64'd11);

        // Five single steps.
        s = nop(); s.step_wr = 1'b1; s.step_wdata = 64'd5;
        cyc(s);
        s = nop(); s.resume_req = 1'b1;
        cyc(s);
        s = nop(); s.tick = 1'b1;
        repeat (8) cyc(s);
        cyc(nop());
        check("step_cause", {61'd0, cause}, 64'd2);
        check("step_count", count, 64'd16);
        check("step_left", step, 64'd0);

        // trig on the final step tick, then resume with trig still high.
        s = nop(); s.step_wr = 1'b1; s.step_wdata = 64'd2;
        cyc(s);
        s = nop(); s.resume_req = 1'b1;
        cyc(s);
        s = nop(); s.tick = 1'b1;
        cyc(s);
        s.trig = 1'b1;
        cyc(s);
        s = nop(); s.trig = 1'b1;
        cyc(s);
        check("step_trig_cause", {61'd0, cause}, 64'd3);
        s.resume_req = 1'b1;
        cyc(s);
        s = nop(); s.trig = 1'b1; s.tick = 1'b1;
        cyc(s);
        cyc(nop());
        check("retrig_cause", {61'd0, cause}, 64'd1);

        // Scan with a dropped same-cycle resume.
        s = nop(); s.scan_req = 1'b1; s.resume_req = 1'b1;
        cyc(s);
        repeat (4) cyc(nop());
        check("scan_wait_busy", {63'd0, busy}, 64'd1);
        check("scan_wait_mode", {63'd0, scan_mode}, 64'd0);
        s = nop(); s.idle = 1'b1;
        cyc(s);
        cyc(nop());
        check("scan_mode_up", {63'd0, scan_mode}, 64'd1);
        s = nop(); s.scan_done = 1'b1;
        cyc(s);
        cyc(nop());
        check("scan_cause_kept", {61'd0, cause}, 64'd1);
        check("scan_back_paused", {63'd0, run_mode}, 64'd0);

        // Counter wrap and load-over-increment.
        s = nop(); s.resume_req = 1'b1;
        cyc(s);
        s = nop(); s.count_wr = 1'b1; s.count_wdata = '1;
        cyc(s);
        s = nop(); s.tick = 1'b1;
        cyc(s);
        cyc(nop());
        check("count_wrap", count, 64'd0);
        s = nop(); s.tick = 1'b1; s.count_wr = 1'b1; s.count_wdata = 64'd123;
        cyc(s);
        cyc(nop());
        check("count_load_wins", count, 64'd123);

        // Async reset in the middle of a scan.
        s = nop(); s.pause_req = 1'b1; s.tick = 1'b1;
        cyc(s);
        s = nop(); s.scan_req = 1'b1;
        cyc(s);
        s = nop(); s.idle = 1'b1;
        cyc(s);
        cyc(nop());
        check("pre_reset_scan", {63'd0, scan_mode}, 64'd1);
        reset_dut();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            s = nop();
            s.tick       = ($urandom_range(0, 1) == 0);
            s.trig       = ($urandom_range(0, 19) == 0);
            s.idle       = ($urandom_range(0, 1) == 0);
            s.pause_req  = ($urandom_range(0, 15) == 0);
            s.resume_req = ($urandom_range(0, 7) == 0);
            s.scan_req   = ($urandom_range(0, 15) == 0);
            s.scan_done  = ($urandom_range(0, 3) == 0);
            s.count_wr   = ($urandom_range(0, 63) == 0);
            s.count_wdata = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                                        : 64'hFFFF_FFFF_FFFF_FFFE;
            s.step_wr    = ($urandom_range(0, 31) == 0);
            s.step_wdata = 64'($urandom_range(0, 6));
            cyc(s);
        end
        cyc(nop());

        @(negedge host_clk);
        @(negedge host_clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
